// File: rtl/vga_timing_gen.sv
// VGA raster timing: hpos/vpos counters with combinational sync, visible and frame decodes.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_count register and port.
module vga_timing_gen #(
    parameter int H_VIEW     = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VIEW     = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       visible,
    output logic       hsync,
    output logic       vsync,
    output logic       hmax,
    output logic       vmax,
    output logic       frame_end
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

    // 11-bit thresholds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VIEW);
    localparam logic [10:0] V_VIS    = 11'(V_VIEW);
    localparam logic [10:0] HS_BEG   = 11'(H_VIEW + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VIEW + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_VIEW + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VIEW + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL %0d exceeds 1024", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
    end

    logic [10:0] hx, vx;
    logic        hs_act, vs_act;

    assign hx     = {1'b0, hpos};
    assign vx     = {1'b0, vpos};
    assign hmax   = (hx == H_LAST);
    assign vmax   = (vx == V_LAST);
    assign hs_act = (hx >= HS_BEG) && (hx < HS_END);
    assign vs_act = (vx >= VS_BEG) && (vx < VS_END);

    // Reset masks the decodes so the sync pins sit idle while the counters restart
    assign visible   = !reset && (hx < H_VIS) && (vx < V_VIS);
    assign hsync     = (!reset && hs_act) ? H_SYNC_POL : ~H_SYNC_POL;
    assign vsync     = (!reset && vs_act) ? V_SYNC_POL : ~V_SYNC_POL;
    assign frame_end = !reset && hmax && vmax && pix_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos <= '0;
            vpos <= '0;
        end else if (pix_en) begin
            if (hmax) begin
                hpos <= '0;
                vpos <= vmax ? '0 : vpos + 10'd1;
            end else begin
                hpos <= hpos + 10'd1;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            frame_count <= '0;
        else if (frame_end)
            frame_count <= frame_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line-level timing and a tiny
// instance (15x10 total, active-high syncs) for frame-level behaviour.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       pen_d, pen_s;
    logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic       d_visible, d_hsync, d_vsync, d_hmax, d_vmax, d_frame_end;
    logic       s_visible, s_hsync, s_vsync, s_hmax, s_vmax, s_frame_end;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] d_frame_count, s_frame_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .reset(reset), .pix_en(pen_d),
        .hpos(d_hpos), .vpos(d_vpos), .visible(d_visible),
        .hsync(d_hsync), .vsync(d_vsync), .hmax(d_hmax), .vmax(d_vmax),
        .frame_end(d_frame_end)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(d_frame_count)
`endif
    );

    // H: 8+2+3+2 = 15, hsync on 10..12; V: 6+1+2+1 = 10, vsync on lines 7..8
    vga_timing_gen #(
        .H_VIEW(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VIEW(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .reset(reset), .pix_en(pen_s),
        .hpos(s_hpos), .vpos(s_vpos), .visible(s_visible),
        .hsync(s_hsync), .vsync(s_vsync), .hmax(s_hmax), .vmax(s_vmax),
        .frame_end(s_frame_end)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(s_frame_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lows, fe_cnt, sx, sy;
        reset = 1'b1;
        pen_d = 1'b0;
        pen_s = 1'b0;
        tick();
        tick();

        // Reset state: (0,0) would decode visible, but reset masks it
        chk("rst_hpos", d_hpos, 0);
        chk("rst_vpos", d_vpos, 0);
        chk("rst_visible", d_visible, 0);
        chk("rst_hsync", d_hsync, 1);
        chk("rst_vsync", d_vsync, 1);
        chk("rst_frame_end", d_frame_end, 0);
        chk("rst_s_hsync", s_hsync, 0);
        chk("rst_s_vsync", s_vsync, 0);
        chk("rst_s_visible", s_visible, 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("rst_d_fcnt", d_frame_count, 0);
`endif

        reset = 1'b0;
        #1;
        chk("rel_visible", d_visible, 1);
        chk("rel_hsync", d_hsync, 1);
        chk("rel_s_visible", s_visible, 1);

        // Full line 0 with per-tick checks, ending at (0,1)
        pen_d = 1'b1;
        lows = 0;
        for (int i = 1; i <= 800; i++) begin
            int k;
            tick();
            k = i % 800;
            chk("line_hpos", d_hpos, k);
            chk("line_vpos", d_vpos, (i == 800) ? 1 : 0);
            chk("line_hmax", d_hmax, (k == 799) ? 1 : 0);
            chk("line_hsync", d_hsync, (k >= 656 && k < 752) ? 0 : 1);
            chk("line_visible", d_visible, (k < 640) ? 1 : 0);
            chk("line_frame_end", d_frame_end, 0);
            if (d_hsync == 1'b0) lows++;
        end
        chk("hsync_width", lows, 96);
        chk("wrap_hpos", d_hpos, 0);
        chk("wrap_vpos", d_vpos, 1);

        // pix_en 1,0,0,1 from hpos=10
        for (int i = 0; i < 10; i++) tick();
        chk("pe_start", d_hpos, 10);
        tick();
        chk("pe_1", d_hpos, 11);
        pen_d = 1'b0;
        tick();
        chk("pe_0a", d_hpos, 11);
        tick();
        chk("pe_0b", d_hpos, 11);
        pen_d = 1'b1;
        tick();
        chk("pe_1b", d_hpos, 12);

        // Mid-line reset inside the hsync window
        for (int i = 0; i < 688; i++) tick();
        chk("mid_hpos", d_hpos, 700);
        chk("mid_vpos", d_vpos, 1);
        chk("mid_hsync_act", d_hsync, 0);
        reset = 1'b1;
        #1;
        chk("midrst_hsync", d_hsync, 1);
        chk("midrst_vsync", d_vsync, 1);
        chk("midrst_visible", d_visible, 0);
        tick();
        chk("midrst_hpos", d_hpos, 0);
        chk("midrst_vpos", d_vpos, 0);
        reset = 1'b0;
        pen_d = 1'b0;
        #1;
        chk("post_visible", d_visible, 1);

        // Small instance: two full frames against an independent position model
        pen_s = 1'b1;
        sx = 0;
        sy = 0;
        fe_cnt = 0;
        chk("s_start_hsync", s_hsync, 0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (sx == 14) begin
                sx = 0;
                sy = (sy == 9) ? 0 : sy + 1;
            end else begin
                sx = sx + 1;
            end
            chk("s_hpos", s_hpos, sx);
            chk("s_vpos", s_vpos, sy);
            chk("s_visible", s_visible, (sx < 8 && sy < 6) ? 1 : 0);
            chk("s_hsync", s_hsync, (sx >= 10 && sx <= 12) ? 1 : 0);
            chk("s_vsync", s_vsync, (sy == 7 || sy == 8) ? 1 : 0);
            chk("s_hmax", s_hmax, (sx == 14) ? 1 : 0);
            chk("s_vmax", s_vmax, (sy == 9) ? 1 : 0);
            chk("s_frame_end", s_frame_end, (sx == 14 && sy == 9) ? 1 : 0);
            if (s_frame_end) fe_cnt++;
        end
        chk("s_fe_count", fe_cnt, 2);
        chk("s_frame_wrap_h", s_hpos, 0);
        chk("s_frame_wrap_v", s_vpos, 0);

        // Park on the last pixel with pix_en low: no frame_end while held
        for (int i = 0; i < 149; i++) tick();
        chk("park_hpos", s_hpos, 14);
        chk("park_vpos", s_vpos, 9);
        chk("park_fe_en", s_frame_end, 1);
        pen_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("park_fe_held", s_frame_end, 0);
            chk("park_hmax", s_hmax, 1);
            chk("park_vmax", s_vmax, 1);
            chk("park_visible", s_visible, 0);
            tick();
        end
        chk("park_hold_h", s_hpos, 14);
        pen_s = 1'b1;
        #1;
        chk("park_fe_release", s_frame_end, 1);
        tick();
        chk("park_next_h", s_hpos, 0);
        chk("park_next_v", s_vpos, 0);

`ifdef VGA_FRAME_COUNT_EN
        chk("fcnt_3", s_frame_count, 3);
        chk("fcnt_d0", d_frame_count, 0);
        for (int i = 0; i < 252 * 150; i++) tick();
        chk("fcnt_255", s_frame_count, 255);
        for (int i = 0; i < 150; i++) tick();
        chk("fcnt_wrap", s_frame_count, 0);
        for (int i = 0; i < 150; i++) tick();
        chk("fcnt_1", s_frame_count, 1);
        reset = 1'b1;
        tick();
        chk("fcnt_rst", s_frame_count, 0);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
